zeroriscy_multdiv_serial: RTL and testbench

- Iterative RV32M multiply/divide engine for the zero-riscy EX stage.
- Produces results one bit per cycle and has no adder of its own for the datapath. Each iteration's 33-bit add is issued to the shared ALU adder through the multdiv operand port, and the sum is consumed back.
- It is the initiator side of the ALU's multdiv adder interface.
- Its ready output is the EX stage's stall source while a mult/div is pending.

---
 rtl/zeroriscy_multdiv_serial.sv | 208 ++++++++++++++++++++
 tb/tb_zeroriscy_multdiv_serial.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_multdiv_serial.sv
// Iterative RV32M multiply/divide engine: one result bit per cycle, every add
// is borrowed from the shared ALU adder through the multdiv operand port.
module zeroriscy_multdiv_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  input  logic [33:0] alu_adder_ext_i,
  input  logic [31:0] alu_adder_i,
  output logic        ready_o,
  output logic [31:0] multdiv_result_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned XW = DW + 1;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sel_hi_q, sel_hi_d;
  logic          signed_b_q, signed_b_d;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic          dz_q, dz_d;
  logic [XW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [XW-1:0] mcd_q, mcd_d;
  logic [XW-1:0] mcd_neg_q, mcd_neg_d;
  logic [XW-1:0] opa_q, opa_d;
  logic [XW-1:0] opb_q, opb_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] result_q, result_d;

  logic          en;
  logic [XW-1:0] a33, b33;
  logic          unused_adder;

  function automatic logic [XW-1:0] neg33(input logic [XW-1:0] x);
    return XW'(~x + XW'(1));
  endfunction

  function automatic logic [DW-1:0] neg32(input logic [DW-1:0] x);
    return DW'(~x + DW'(1));
  endfunction

  assign en  = mult_en_i | div_en_i;
  assign a33 = {signed_mode_i[0] & op_a_i[DW-1], op_a_i};
  assign b33 = {signed_mode_i[1] & op_b_i[DW-1], op_b_i};

  // The truncated sum is only a debug tap of the ALU.
  assign unused_adder = ^alu_adder_i;

  // Next-state, datapath update and next ALU operands.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    sel_hi_d   = sel_hi_q;
    signed_b_d = signed_b_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcd_d      = mcd_q;
    mcd_neg_d  = mcd_neg_q;
    opa_d      = '0;
    opb_d      = '0;
    ready_d    = 1'b0;
    result_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = CALC;
          cnt_d      = CW'(DW - 1);
          is_div_d   = ~mult_en_i;
          sel_hi_d   = operator_i[0];
          signed_b_d = signed_mode_i[1];
          hi_d       = '0;
          if (mult_en_i) begin
            lo_d      = b33[DW-1:0];
            mcd_d     = a33;
            mcd_neg_d = neg33(a33);
            neg_q_d   = 1'b0;
            neg_r_d   = 1'b0;
            dz_d      = 1'b0;
          end else begin
            // Divide works on magnitudes; mcd holds -|b| so each trial is an add.
            lo_d      = a33[XW-1] ? DW'(neg33(a33)) : a33[DW-1:0];
            mcd_d     = b33[XW-1] ? b33 : neg33(b33);
            mcd_neg_d = '0;
            neg_q_d   = a33[XW-1] ^ b33[XW-1];
            neg_r_d   = a33[XW-1];
            dz_d      = (op_b_i == '0);
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (!is_div_q) begin
          // Bit 33 is the true sign: the 33-bit sum overflows for unsigned operands.
          hi_d = alu_adder_ext_i[XW:1];
          lo_d = {alu_adder_ext_i[0], lo_q[DW-1:1]};
        end else if (!alu_adder_ext_i[XW]) begin
          hi_d = alu_adder_ext_i[XW-1:0];
          lo_d = {lo_q[DW-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[DW-1:0], lo_q[DW-1]};
          lo_d = {lo_q[DW-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FINISH;
          ready_d = 1'b1;
          if (!is_div_q) begin
            result_d = sel_hi_q ? hi_d[DW-1:0] : lo_d;
          end else if (sel_hi_q) begin
            result_d = neg_r_q ? neg32(hi_d[DW-1:0]) : hi_d[DW-1:0];
          end else begin
            result_d = (neg_q_q & ~dz_q) ? neg32(lo_d) : lo_d;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping the request aborts from any state without a result.
    if (!en) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = '0;
    end

    if (state_d == CALC) begin
      if (is_div_d) begin
        opa_d = {hi_d[DW-1:0], lo_d[DW-1]};
        opb_d = mcd_d;
      end else begin
        opa_d = hi_d;
        if (lo_d[0]) begin
          opb_d = ((cnt_d == '0) && signed_b_d) ? mcd_neg_d : mcd_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      signed_b_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcd_q      <= '0;
      mcd_neg_q  <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      ready_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      sel_hi_q   <= sel_hi_d;
      signed_b_q <= signed_b_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcd_q      <= mcd_d;
      mcd_neg_q  <= mcd_neg_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
    end
  end

  assign alu_operand_a_o  = opa_q;
  assign alu_operand_b_o  = opb_q;
  assign ready_o          = ready_q;
  assign multdiv_result_o = result_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_serial.sv
// Bench for zeroriscy_multdiv_serial: models the shared ALU adder and checks
// results and latency against a plain-arithmetic RV32M reference.
module tb_zeroriscy_multdiv_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mult_en, div_en;
  logic [1:0]  operator, signed_mode;
  logic [31:0] op_a, op_b;
  logic [32:0] alu_operand_a, alu_operand_b;
  logic [33:0] alu_adder_ext;
  logic [31:0] alu_adder;
  logic        ready;
  logic [31:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Shared ALU adder: sign-extended A + sign-extended B.
  assign alu_adder_ext = {alu_operand_a[32], alu_operand_a} + {alu_operand_b[32], alu_operand_b};
  assign alu_adder     = alu_adder_ext[31:0];

  zeroriscy_multdiv_serial dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mult_en_i        (mult_en),
    .div_en_i         (div_en),
    .operator_i       (operator),
    .signed_mode_i    (signed_mode),
    .op_a_i           (op_a),
    .op_b_i           (op_b),
    .alu_operand_a_o  (alu_operand_a),
    .alu_operand_b_o  (alu_operand_b),
    .alu_adder_ext_i  (alu_adder_ext),
    .alu_adder_i      (alu_adder),
    .ready_o          (ready),
    .multdiv_result_o (result)
  );

  function automatic logic [31:0] model(input bit is_mul, input logic [1:0] op,
                                        input logic [1:0] sm, input logic [31:0] a,
                                        input logic [31:0] b);
    longint va;
    longint vb;
    logic [63:0] p;
    va = sm[0] ? longint'($signed(a)) : longint'(a);
    vb = sm[1] ? longint'($signed(b)) : longint'(b);
    if (is_mul) begin
      p = 64'(va * vb);
      return op[0] ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    return op[0] ? 32'(va % vb) : 32'(va / vb);
  endfunction

  task automatic start_req(input bit is_mul, input logic [1:0] op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b);
    mult_en     = is_mul;
    div_en      = !is_mul;
    operator    = op;
    signed_mode = sm;
    op_a        = a;
    op_b        = b;
  endtask

  task automatic idle_req();
    mult_en = 1'b0;
    div_en  = 1'b0;
  endtask

  task automatic wait_ready(output logic [31:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input bit is_mul, input logic [1:0] op,
                          input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    start_req(is_mul, op, sm, a, b);
    wait_ready(res, lat);
    idle_req();
    n_vec++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 33", name, lat);
    end
    n_vec++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %08h want %08h", name, res, exp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    n_vec++;
    if (ready !== 1'b0 || result !== 32'd0 || alu_operand_a !== 33'd0 || alu_operand_b !== 33'd0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b res=%08h opa=%09h opb=%09h want all 0",
               name, ready, result, alu_operand_a, alu_operand_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_req();
    operator = 2'b00; signed_mode = 2'b00; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    // IDLE with no request stays quiet.
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_directed();
    check_op("mul_7xm3",      1'b1, 2'b00, 2'b11, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    check_op("mulh_min_min",  1'b1, 2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    check_op("mulhu_max",     1'b1, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_op("mulhsu_max",    1'b1, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("div_m7_2",      1'b0, 2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    check_op("rem_m7_2",      1'b0, 2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    check_op("divu_100_7",    1'b0, 2'b10, 2'b00, 32'd100,       32'd7,         32'd14);
    check_op("remu_100_7",    1'b0, 2'b11, 2'b00, 32'd100,       32'd7,         32'd2);
    check_op("divu_5_0",      1'b0, 2'b10, 2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF);
    check_op("remu_5_0",      1'b0, 2'b11, 2'b00, 32'd5,         32'd0,         32'd5);
    check_op("div_ovf",       1'b0, 2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check_op("rem_ovf",       1'b0, 2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_abort();
    bit saw_ready = 1'b0;
    start_req(1'b0, 2'b10, 2'b00, 32'd1000, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    div_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (ready === 1'b1) saw_ready = 1'b1;
    n_vec++;
    if (saw_ready) begin
      n_fail++;
      $display("FAIL abort_no_ready: got ready seen=1 want 0");
    end
    check_idle_outputs("abort_idle");
    check_op("rerequest_6x7", 1'b1, 2'b00, 2'b11, 32'd6, 32'd7, 32'd42);
  endtask

  task automatic test_operand_change();
    logic [31:0] res;
    int lat;
    logic [31:0] exp;
    exp = model(1'b1, 2'b01, 2'b11, 32'h1234_5678, 32'hF00D_BEEF);
    start_req(1'b1, 2'b01, 2'b11, 32'h1234_5678, 32'hF00D_BEEF);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    operator = 2'b00; signed_mode = 2'b00; op_a = $urandom; op_b = $urandom;
    wait_ready(res, lat);
    idle_req();
    n_vec++;
    if (lat !== 28 || res !== exp) begin
      n_fail++;
      $display("FAIL operand_change: got lat=%0d res=%08h want lat=28 res=%08h", lat, res, exp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_req(1'b1, 2'b00, 2'b11, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_calc");
    idle_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_op("div_9_3_after_reset", 1'b0, 2'b10, 2'b11, 32'd9, 32'd3, 32'd3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    logic [31:0] e1, e2;
    e1 = model(1'b0, 2'b10, 2'b11, 32'hFFFF_0123, 32'd77);
    e2 = model(1'b0, 2'b11, 2'b11, 32'hFFFF_0123, 32'd77);
    start_req(1'b0, 2'b10, 2'b11, 32'hFFFF_0123, 32'd77);
    wait_ready(res, lat);
    n_vec++;
    if (lat !== 33 || res !== e1) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d res=%08h want lat=33 res=%08h", lat, res, e1);
    end
    operator = 2'b11;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_ready: got %b want 0", ready);
    end
    wait_ready(res, lat);
    idle_req();
    n_vec++;
    if (lat !== 33 || res !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d res=%08h want lat=33 res=%08h", lat, res, e2);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] sp [4];
    logic [31:0] a, b;
    logic [1:0]  op, sm;
    bit          is_mul;
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'h8000_0000; sp[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      op     = 2'($urandom_range(0, 3));
      sm     = 2'($urandom_range(0, 3));
      a      = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      b      = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      check_op($sformatf("rand%0d_%s_op%0d_sm%0d_%08h_%08h", i, is_mul ? "mul" : "div", op, sm, a, b),
               is_mul, op, sm, a, b, model(is_mul, op, sm, a, b));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
